// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared state encoding, register map and CTRL field layout
//               for the memory-mapped countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] c_addr_ctrl   = 2'd0;
    localparam logic [1:0] c_addr_preset = 2'd1;
    localparam logic [1:0] c_addr_count  = 2'd2;

    localparam int c_en_bit   = 0;
    localparam int c_mode_lsb = 1;
    localparam int c_im_bit   = 3;

    localparam logic [1:0] c_mode_auto = 2'b01;

endpackage
`default_nettype wire

// File: rtl/timer_unit.sv
`default_nettype none
// ============================================================================
// Module      : timer_unit
// Description : Bus-programmable countdown timer with one-shot / auto-reload
//               modes and a maskable interrupt request.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_unit
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_ctrl;
    logic [CNT_W-1:0]   r_preset;
    logic [CNT_W-1:0]   r_count;
    logic               r_irq_flag;

    logic               w_en;
    logic               w_auto;
    logic               w_ctrl_wr;
    logic               w_preset_wr;
    logic               w_expire;

    assign w_en        = r_ctrl[c_en_bit];
    assign w_auto      = (r_ctrl[c_mode_lsb +: 2] == c_mode_auto);
    assign w_ctrl_wr   = we && (addr == c_addr_ctrl);
    assign w_preset_wr = we && (addr == c_addr_preset);
    // A preset of 0 expires exactly like a preset of 1.
    assign w_expire    = (r_state == ST_CNT) && w_en && (r_count <= CNT_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_en) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = w_en ? ST_CNT : ST_IDLE;
            ST_CNT: begin
                if (!w_en)         w_state_nxt = ST_IDLE;
                else if (w_expire) w_state_nxt = ST_INT;
            end
            ST_INT:  w_state_nxt = w_auto ? ST_LOAD : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_ctrl     <= 4'd0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // A software CTRL write overrides the hardware EN clear in INT.
            if (w_ctrl_wr) begin
                r_ctrl <= din[3:0];
            end else if ((r_state == ST_INT) && !w_auto) begin
                r_ctrl[c_en_bit] <= 1'b0;
            end

            if (w_preset_wr) begin
                r_preset <= din[CNT_W-1:0];
            end

            if (r_state == ST_LOAD) begin
                r_count <= r_preset;
            end else if ((r_state == ST_CNT) && w_en) begin
                r_count <= w_expire ? '0 : (r_count - CNT_W'(1));
            end

            if (w_ctrl_wr) begin
                r_irq_flag <= 1'b0;
            end else if (w_expire) begin
                r_irq_flag <= 1'b1;
            end else if ((r_state == ST_INT) && w_auto) begin
                r_irq_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            c_addr_ctrl:   dout = {28'd0, r_ctrl};
            c_addr_preset: dout = 32'(r_preset);
            c_addr_count:  dout = 32'(r_count);
            default:       dout = 32'd0;
        endcase
    end

    assign irq = r_irq_flag & r_ctrl[c_im_bit];

endmodule
`default_nettype wire

// File: tb/tb_timer_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_unit
// Description : Directed and randomized self-checking bench for timer_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_unit;

    logic        clk;
    logic        reset;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference model: timer phase plus the software-visible registers.
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_CNT  = 2;
    localparam int P_INT  = 3;

    int          m_phase  = P_IDLE;
    bit          m_en     = 0;
    bit [1:0]    m_mode   = 0;
    bit          m_im     = 0;
    bit [31:0]   m_preset = 0;
    bit [31:0]   m_count  = 0;
    bit          m_flag   = 0;

    timer_unit #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_dout(input bit [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input bit w, input bit [1:0] a, input bit [31:0] d, input bit rn);
        bit clear_en;
        int nxt;
        clear_en = 0;
        if (!rn) begin
            m_phase = P_IDLE; m_en = 0; m_mode = 0; m_im = 0;
            m_preset = 0; m_count = 0; m_flag = 0;
            return;
        end
        nxt = m_phase;
        case (m_phase)
            P_IDLE: if (m_en) nxt = P_LOAD;
            P_LOAD: begin
                m_count = m_preset;
                nxt = m_en ? P_CNT : P_IDLE;
            end
            P_CNT: begin
                if (!m_en) nxt = P_IDLE;
                else if (m_count > 1) m_count = m_count - 1;
                else begin
                    m_count = 0;
                    m_flag  = 1;
                    nxt     = P_INT;
                end
            end
            default: begin
                if (m_mode == 2'b01) begin
                    m_flag = 0;
                    nxt    = P_LOAD;
                end else begin
                    clear_en = 1;
                    nxt      = P_IDLE;
                end
            end
        endcase
        m_phase = nxt;
        if (w && a == 2'd0) begin
            {m_im, m_mode, m_en} = d[3:0];
            m_flag = 0;
        end else if (clear_en) begin
            m_en = 0;
        end
        if (w && a == 2'd1) m_preset = d;
    endtask

    // One clock: drive, advance model, then compare every readable word and irq.
    task automatic cyc(input bit w, input bit [1:0] a, input bit [31:0] d, input bit rn);
        we = w; addr = a; din = d; reset = rn;
        @(posedge clk);
        model_step(w, a, d, rn);
        #1;
        we = 1'b0; reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            addr = 2'(k);
            #0.5;
            chk($sformatf("model_dout_a%0d", k), dout, exp_dout(2'(k)));
        end
        chk("model_irq", {31'd0, irq}, {31'd0, m_flag & m_im});
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 2'd0, 32'd0, 1'b1);
    endtask

    task automatic peek_eq(input bit [1:0] a, input logic [31:0] e, input string tag);
        addr = a;
        #1;
        chk(tag, dout, e);
    endtask

    initial begin
        bit [1:0]  ra;
        bit [31:0] rd;
        int        r;

        reset = 1'b0; we = 1'b0; addr = 2'd0; din = 32'd0;

        // Reset held low for two cycles
        cyc(1'b0, 2'd0, 32'd0, 1'b0);
        cyc(1'b0, 2'd0, 32'd0, 1'b0);
        peek_eq(2'd0, 32'd0, "rst_ctrl");
        peek_eq(2'd1, 32'd0, "rst_preset");
        peek_eq(2'd2, 32'd0, "rst_count");
        chk("rst_irq", {31'd0, irq}, 32'd0);

        // One-shot, PRESET=3
        cyc(1'b1, 2'd1, 32'd3, 1'b1);
        cyc(1'b1, 2'd0, 32'h9, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            idle(1);
            if (k >= 2 && k <= 5) peek_eq(2'd2, 32'(5 - k), "os_count");
            if (k >= 5) chk("os_irq", {31'd0, irq}, 32'd1);
            if (k == 6) peek_eq(2'd0, 32'h8, "os_en_cleared");
        end
        idle(2);
        chk("os_irq_hold", {31'd0, irq}, 32'd1);
        cyc(1'b1, 2'd0, 32'h8, 1'b1);
        chk("os_irq_clear", {31'd0, irq}, 32'd0);

        // Auto-reload, PRESET=2: one-cycle pulse every 4 cycles
        cyc(1'b1, 2'd1, 32'd2, 1'b1);
        cyc(1'b1, 2'd0, 32'hB, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            idle(1);
            chk("ar_irq", {31'd0, irq}, (k % 4 == 0) ? 32'd1 : 32'd0);
        end
        cyc(1'b1, 2'd0, 32'h0, 1'b1);
        idle(2);

        // Pause at COUNT=5, then resume reloads from PRESET
        cyc(1'b1, 2'd1, 32'd9, 1'b1);
        cyc(1'b1, 2'd0, 32'h1, 1'b1);
        idle(5);
        peek_eq(2'd2, 32'd6, "pause_pre");
        cyc(1'b1, 2'd0, 32'h0, 1'b1);
        idle(2);
        peek_eq(2'd2, 32'd5, "pause_frozen");
        cyc(1'b1, 2'd0, 32'h1, 1'b1);
        idle(2);
        peek_eq(2'd2, 32'd9, "resume_reload");
        cyc(1'b1, 2'd0, 32'h0, 1'b1);
        idle(2);

        // Masked expiry, then a CTRL write clears the hidden flag
        cyc(1'b1, 2'd1, 32'd1, 1'b1);
        cyc(1'b1, 2'd0, 32'h1, 1'b1);
        idle(4);
        chk("mask_irq", {31'd0, irq}, 32'd0);
        cyc(1'b1, 2'd0, 32'h8, 1'b1);
        chk("mask_wr_clears", {31'd0, irq}, 32'd0);

        // CTRL write of 0x1 in the INT cycle keeps EN and clears the flag
        cyc(1'b1, 2'd1, 32'd2, 1'b1);
        cyc(1'b1, 2'd0, 32'h9, 1'b1);
        idle(4);
        chk("coll_pre_irq", {31'd0, irq}, 32'd1);
        cyc(1'b1, 2'd0, 32'h1, 1'b1);
        peek_eq(2'd0, 32'h1, "coll_en_kept");
        idle(2);
        peek_eq(2'd2, 32'd2, "coll_restart");
        cyc(1'b1, 2'd0, 32'h0, 1'b1);
        idle(2);

        // Reset in the middle of a count
        cyc(1'b1, 2'd1, 32'd20, 1'b1);
        cyc(1'b1, 2'd0, 32'h1, 1'b1);
        idle(15);
        peek_eq(2'd2, 32'd7, "mid_count");
        cyc(1'b0, 2'd0, 32'd0, 1'b0);
        peek_eq(2'd0, 32'd0, "mid_rst_ctrl");
        peek_eq(2'd1, 32'd0, "mid_rst_preset");
        peek_eq(2'd2, 32'd0, "mid_rst_count");

        // PRESET=0 expires on the first CNT cycle
        cyc(1'b1, 2'd0, 32'h9, 1'b1);
        idle(2);
        chk("p0_irq_low", {31'd0, irq}, 32'd0);
        idle(1);
        chk("p0_irq_high", {31'd0, irq}, 32'd1);
        cyc(1'b1, 2'd0, 32'h0, 1'b1);
        idle(1);

        // Writes to COUNT and the unmapped word are ignored
        cyc(1'b1, 2'd1, 32'd5, 1'b1);
        cyc(1'b1, 2'd0, 32'h1, 1'b1);
        idle(2);
        cyc(1'b1, 2'd2, 32'h1234, 1'b1);
        peek_eq(2'd2, 32'd4, "wr_count_ignored");
        cyc(1'b1, 2'd3, 32'hFFFF_FFFF, 1'b1);
        peek_eq(2'd3, 32'd0, "addr3_zero");
        peek_eq(2'd2, 32'd3, "wr_addr3_ignored");
        cyc(1'b1, 2'd0, 32'h0, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            r  = int'($urandom_range(0, 99));
            ra = 2'($urandom_range(0, 3));
            case (ra)
                2'd0:    rd = 32'($urandom_range(0, 15));
                2'd1:    rd = 32'($urandom_range(0, 6));
                default: rd = $urandom;
            endcase
            if (r < 2)       cyc(1'b0, ra, rd, 1'b0);
            else if (r < 22) cyc(1'b1, ra, rd, 1'b1);
            else             cyc(1'b0, ra, rd, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
